// File: rtl/gf22_sram_pkg.sv
// Shared types and helpers for the banked GF22 SRAM wrapper with write buffer.
package gf22_sram_pkg;

   localparam int unsigned DATA_W_DEF     = 64;
   localparam int unsigned ADDR_W_DEF     = 14;
   localparam int unsigned NBANKS_DEF     = 2;
   localparam int unsigned WBUF_DEPTH_DEF = 2;

   // Ceiling log2, never below 1 so it can size pointers for depth 1.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return (r == 0) ? 1 : r;
   endfunction

   localparam int unsigned BANK_SEL_W = clog2(NBANKS_DEF);

   typedef struct packed {
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] data;
      logic [DATA_W_DEF-1:0] mask;
      logic                  valid;
   } wb_entry_t;

endpackage

// File: rtl/gf22_sram_wbuf.sv
// Circular write buffer with parallel address compare and oldest-to-youngest masked merge.
module gf22_sram_wbuf
   import gf22_sram_pkg::*;
#(
   parameter int unsigned DEPTH = WBUF_DEPTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  wb_entry_t             push_entry,
   input  logic                  pop,
   output wb_entry_t             head,
   output logic                  full,
   output logic                  empty,
   input  logic [ADDR_W_DEF-1:0] lookup_addr,
   output logic [DATA_W_DEF-1:0] fm,
   output logic [DATA_W_DEF-1:0] fd
);

   localparam int unsigned PTR_W = clog2(DEPTH);
   localparam int unsigned CNT_W = clog2(DEPTH + 1);

   wb_entry_t          entries [DEPTH];
   wb_entry_t          push_v;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               push_ok;
   logic               pop_ok;

   // Explicit compare-and-clear keeps wrap correct for any depth.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign head    = entries[rd_ptr];

   always_comb begin
      push_v       = push_entry;
      push_v.valid = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) entries[i] <= '0;
      end else begin
         if (pop_ok) begin
            entries[rd_ptr].valid <= 1'b0;
            rd_ptr                <= ptr_inc(rd_ptr);
         end
         if (push_ok) begin
            entries[wr_ptr] <= push_v;
            wr_ptr          <= ptr_inc(wr_ptr);
         end
         count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

   // Walk from head so younger entries overwrite older bytes of the same word.
   always_comb begin
      int unsigned idx;
      idx = 0;
      fm  = '0;
      fd  = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         idx = 32'(rd_ptr) + k;
         if (idx >= DEPTH) idx = idx - DEPTH;
         if (entries[PTR_W'(idx)].valid && (entries[PTR_W'(idx)].addr == lookup_addr)) begin
            fm = fm | entries[PTR_W'(idx)].mask;
            fd = (fd & ~entries[PTR_W'(idx)].mask) |
                 (entries[PTR_W'(idx)].data & entries[PTR_W'(idx)].mask);
         end
      end
   end

endmodule

// File: rtl/gf22_sram_be_banked_wbuf.sv
// 1W/1R bit-masked memory over NBANKS single-port banks; same-bank write conflicts
// are parked in a write buffer, drained in order and forwarded to reads.
module gf22_sram_be_banked_wbuf
   import gf22_sram_pkg::*;
#(
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned ADDR_W     = ADDR_W_DEF,
   parameter int unsigned NBANKS     = NBANKS_DEF,
   parameter int unsigned WBUF_DEPTH = WBUF_DEPTH_DEF
) (
   input  logic              CLK,
   input  logic              RSTN,
   input  logic              CE0,
   input  logic [ADDR_W-1:0] A0,
   input  logic [DATA_W-1:0] D0,
   input  logic              WE0,
   input  logic [DATA_W-1:0] WEM0,
   output logic              W_RDY,
   input  logic              CE1,
   input  logic [ADDR_W-1:0] A1,
   output logic [DATA_W-1:0] Q1,
   output logic              Q1_VLD,
   output logic              WB_EMPTY
);

   localparam int unsigned BS_W   = clog2(NBANKS);
   localparam int unsigned WORD_W = ADDR_W - BS_W;
   localparam int unsigned WORDS  = 32'd1 << WORD_W;

   logic [BS_W-1:0]       wbank;
   logic [BS_W-1:0]       rbank;
   logic [BS_W-1:0]       hbank;
   logic [ADDR_W-1:0]     head_addr;
   wb_entry_t             head;
   wb_entry_t             push_entry;
   logic                  wb_full;
   logic                  wb_empty;
   logic                  wr_acc;
   logic                  direct;
   logic                  push;
   logic                  drain;
   logic [DATA_W_DEF-1:0] fm;
   logic [DATA_W_DEF-1:0] fd;

   logic                  bank_rd   [NBANKS];
   logic                  bank_wr   [NBANKS];
   logic [WORD_W-1:0]     bank_addr [NBANKS];
   logic [DATA_W-1:0]     bank_d    [NBANKS];
   logic [DATA_W-1:0]     bank_m    [NBANKS];
   logic [DATA_W-1:0]     bank_q    [NBANKS];

   logic [DATA_W-1:0]     fm_q;
   logic [DATA_W-1:0]     fd_q;
   logic [BS_W-1:0]       sel_q;
   logic                  q1_vld_q;

   assign head_addr = ADDR_W'(head.addr);
   assign wbank     = A0[ADDR_W-1 -: BS_W];
   assign rbank     = A1[ADDR_W-1 -: BS_W];
   assign hbank     = head_addr[ADDR_W-1 -: BS_W];

   // A write goes straight to its bank only when nothing older is still queued.
   assign wr_acc = CE0 & WE0 & ~wb_full;
   assign direct = wr_acc & wb_empty & (~CE1 | (wbank != rbank));
   assign push   = wr_acc & ~direct;
   assign drain  = ~wb_empty & head.valid & (~CE1 | (hbank != rbank));

   always_comb begin
      push_entry.addr  = ADDR_W_DEF'(A0);
      push_entry.data  = DATA_W_DEF'(D0);
      push_entry.mask  = DATA_W_DEF'(WEM0);
      push_entry.valid = 1'b1;
   end

   gf22_sram_wbuf #(
      .DEPTH (WBUF_DEPTH)
   ) u_wbuf (
      .clk         (CLK),
      .rst_n       (RSTN),
      .push        (push),
      .push_entry  (push_entry),
      .pop         (drain),
      .head        (head),
      .full        (wb_full),
      .empty       (wb_empty),
      .lookup_addr (ADDR_W_DEF'(A1)),
      .fm          (fm),
      .fd          (fd)
   );

   // Per-bank port owner: read beats drain beats direct write.
   always_comb begin
      for (int unsigned b = 0; b < NBANKS; b++) begin
         bank_rd[b]   = 1'b0;
         bank_wr[b]   = 1'b0;
         bank_addr[b] = '0;
         bank_d[b]    = '0;
         bank_m[b]    = '0;
         if (CE1 && (rbank == BS_W'(b))) begin
            bank_rd[b]   = 1'b1;
            bank_addr[b] = A1[WORD_W-1:0];
         end else if (drain && (hbank == BS_W'(b))) begin
            bank_wr[b]   = 1'b1;
            bank_addr[b] = head_addr[WORD_W-1:0];
            bank_d[b]    = DATA_W'(head.data);
            bank_m[b]    = DATA_W'(head.mask);
         end else if (direct && (wbank == BS_W'(b))) begin
            bank_wr[b]   = 1'b1;
            bank_addr[b] = A0[WORD_W-1:0];
            bank_d[b]    = D0;
            bank_m[b]    = WEM0;
         end
      end
   end

   // Behavioural stand-in for one GF22_SRAM_SP_<WORDS>x<DATA_W>_HD macro per bank.
   for (genvar b = 0; b < NBANKS; b++) begin : g_bank
      logic [DATA_W-1:0] mem [WORDS];
      logic [DATA_W-1:0] q;

      always_ff @(posedge CLK) begin
         if (bank_wr[b])
            mem[bank_addr[b]] <= (mem[bank_addr[b]] & ~bank_m[b]) | (bank_d[b] & bank_m[b]);
         if (bank_rd[b])
            q <= mem[bank_addr[b]];
      end

      assign bank_q[b] = q;
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         q1_vld_q <= 1'b0;
         fm_q     <= '0;
         fd_q     <= '0;
         sel_q    <= '0;
      end else begin
         q1_vld_q <= CE1;
         if (CE1) begin
            fm_q  <= DATA_W'(fm);
            fd_q  <= DATA_W'(fd);
            sel_q <= rbank;
         end
      end
   end

   assign Q1       = (bank_q[sel_q] & ~fm_q) | (fd_q & fm_q);
   assign Q1_VLD   = q1_vld_q;
   assign W_RDY    = ~wb_full;
   assign WB_EMPTY = wb_empty;

endmodule

// File: tb/tb_gf22_sram_be_banked_wbuf.sv
// Scoreboard bench for gf22_sram_be_banked_wbuf: reads push expected words, a monitor checks Q1 beats.
module tb_gf22_sram_be_banked_wbuf;

   logic        CLK;
   logic        RSTN;
   logic        CE0;
   logic [13:0] A0;
   logic [63:0] D0;
   logic        WE0;
   logic [63:0] WEM0;
   logic        W_RDY;
   logic        CE1;
   logic [13:0] A1;
   logic [63:0] Q1;
   logic        Q1_VLD;
   logic        WB_EMPTY;

   gf22_sram_be_banked_wbuf dut (
      .CLK      (CLK),
      .RSTN     (RSTN),
      .CE0      (CE0),
      .A0       (A0),
      .D0       (D0),
      .WE0      (WE0),
      .WEM0     (WEM0),
      .W_RDY    (W_RDY),
      .CE1      (CE1),
      .A1       (A1),
      .Q1       (Q1),
      .Q1_VLD   (Q1_VLD),
      .WB_EMPTY (WB_EMPTY)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   logic [63:0] model [logic [13:0]];
   logic [63:0] exp_q [$];

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One bus cycle; write acceptance follows W_RDY, and the model only sees the
   // write after this cycle's read expectation is captured.
   task automatic cyc(input bit ce0, input logic [13:0] a0, input logic [63:0] d0,
                      input logic [63:0] m0, input bit ce1, input logic [13:0] a1,
                      input bit apply, output bit acc);
      @(negedge CLK);
      CE0 = ce0; WE0 = ce0; A0 = a0; D0 = d0; WEM0 = m0;
      CE1 = ce1; A1 = a1;
      #1;
      acc = ce0 && W_RDY;
      if (ce1) exp_q.push_back(model[a1]);
      if (acc && apply) model[a0] = (model[a0] & ~m0) | (d0 & m0);
   endtask

   task automatic idle();
      bit dummy;
      cyc(0, '0, '0, '0, 0, '0, 1, dummy);
   endtask

   task automatic rd(input logic [13:0] a);
      bit dummy;
      cyc(0, '0, '0, '0, 1, a, 1, dummy);
   endtask

   always @(posedge CLK) begin
      logic [63:0] e;
      #1;
      if (RSTN) begin
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("q1_vld", 64'(Q1_VLD), 64'd1);
            if (Q1_VLD) check("q1_data", Q1, e);
         end else begin
            check("q1_vld_idle", 64'(Q1_VLD), 64'd0);
         end
      end
   end

   initial begin
      bit          acc;
      logic [13:0] a;
      int          k;

      RSTN = 1'b0; CE0 = 0; WE0 = 0; A0 = '0; D0 = '0; WEM0 = '0; CE1 = 0; A1 = '0;
      repeat (2) @(negedge CLK);
      #1;
      check("rst_w_rdy", 64'(W_RDY), 64'd1);
      check("rst_wb_empty", 64'(WB_EMPTY), 64'd1);
      check("rst_q1_vld", 64'(Q1_VLD), 64'd0);
      @(negedge CLK);
      RSTN = 1'b1;

      // Known contents in both banks for the address pool used below
      for (int i = 0; i < 32; i++) begin
         a = 14'(i);
         cyc(1, a, {18'h0, a, 32'hC0DE_0000 ^ 32'(i)}, '1, 0, '0, 1, acc);
         a = 14'h2000 | 14'(i);
         cyc(1, a, {18'h1, a, 32'hBEEF_0000 ^ 32'(i)}, '1, 0, '0, 1, acc);
      end

      // 1: different-bank write goes direct
      cyc(1, 14'h0010, 64'h1, '1, 1, 14'h2010, 1, acc);
      @(posedge CLK); #1;
      check("t1_acc", 64'(acc), 64'd1);
      check("t1_wb_empty", 64'(WB_EMPTY), 64'd1);
      rd(14'h0010);
      check("t1_model", model[14'h0010], 64'h1);

      // 2: same-bank conflict is buffered, then drains on an idle cycle
      cyc(1, 14'h0005, 64'hAAAA_AAAA_AAAA_AAAA, '1, 1, 14'h0007, 1, acc);
      @(posedge CLK); #1;
      check("t2_wb_busy", 64'(WB_EMPTY), 64'd0);
      idle();
      @(posedge CLK); #1;
      check("t2_wb_drained", 64'(WB_EMPTY), 64'd1);
      rd(14'h0005);

      // 3: W_RDY backpressure under continuous bank0 reads, in-order drain
      cyc(1, 14'h0003, 64'h1234_5678_9ABC_DEF0, 64'h0000_FFFF_0000_FFFF, 1, 14'h0003, 1, acc);
      check("t3_acc1", 64'(acc), 64'd1);
      cyc(1, 14'h0004, 64'h0F0F_0F0F_0F0F_0F0F, 64'hFFFF_FFFF_0000_0000, 1, 14'h0003, 1, acc);
      check("t3_acc2", 64'(acc), 64'd1);
      cyc(1, 14'h0003, 64'hDEAD_BEEF_CAFE_F00D, 64'hFF00_0000_00FF_FF00, 1, 14'h0004, 1, acc);
      check("t3_acc3_stall", 64'(acc), 64'd0);
      cyc(1, 14'h0003, 64'hDEAD_BEEF_CAFE_F00D, 64'hFF00_0000_00FF_FF00, 0, '0, 1, acc);
      check("t3_acc4_stall", 64'(acc), 64'd0);
      cyc(1, 14'h0003, 64'hDEAD_BEEF_CAFE_F00D, 64'hFF00_0000_00FF_FF00, 0, '0, 1, acc);
      check("t3_acc5", 64'(acc), 64'd1);
      idle();
      @(posedge CLK); #1;
      check("t3_wb_drained", 64'(WB_EMPTY), 64'd1);
      rd(14'h0003);
      rd(14'h0004);

      // 4: two buffered partial writes to one word, youngest wins per bit
      cyc(1, 14'h0005, 64'hFFFF, '1, 0, '0, 1, acc);
      cyc(1, 14'h0005, 64'h11, 64'h00FF, 1, 14'h0006, 1, acc);
      cyc(1, 14'h0005, 64'h22, 64'h0F0F, 1, 14'h0006, 1, acc);
      rd(14'h0005);
      check("t4_model", model[14'h0005], 64'hF012);
      idle();
      idle();
      rd(14'h0005);

      // 5: reset with two buffered writes discards them
      cyc(1, 14'h0008, 64'h5555_5555_5555_5555, '1, 1, 14'h0009, 0, acc);
      cyc(1, 14'h2008, 64'h6666_6666_6666_6666, '1, 1, 14'h000A, 0, acc);
      @(posedge CLK); #1;
      check("t5_full", 64'(W_RDY), 64'd0);
      @(negedge CLK);
      CE0 = 0; WE0 = 0; CE1 = 0;
      RSTN = 1'b0;
      #1;
      check("t5_w_rdy", 64'(W_RDY), 64'd1);
      check("t5_wb_empty", 64'(WB_EMPTY), 64'd1);
      check("t5_q1_vld", 64'(Q1_VLD), 64'd0);
      @(negedge CLK);
      RSTN = 1'b1;
      rd(14'h0008);
      rd(14'h2008);

      // 6: random 1W/1R traffic over the initialised pool
      for (int i = 0; i < 10000; i++) begin
         logic [13:0] wa, ra;
         logic [63:0] wd, wm;
         int          r;
         wa = {1'($urandom), 8'h00, 5'($urandom)};
         ra = {1'($urandom), 8'h00, 5'($urandom)};
         wd = {$urandom, $urandom};
         r  = $urandom_range(0, 3);
         wm = (r == 0) ? '1 : (r == 1) ? '0 : {$urandom, $urandom};
         cyc(($urandom_range(0, 3) != 0), wa, wd, wm, ($urandom_range(0, 3) != 0), ra, 1, acc);
      end
      k = 0;
      while (k < 20) begin
         idle();
         @(posedge CLK); #1;
         if (WB_EMPTY) break;
         k++;
      end
      check("t6_drain_done", 64'(WB_EMPTY), 64'd1);
      for (int i = 0; i < 32; i++) begin
         rd(14'(i));
         rd(14'h2000 | 14'(i));
      end

      idle();
      idle();
      check("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
